// File: rtl/cc_gen_track.sv
// LC-3b condition-code producer: holds n/z/p from writeback and counts in-flight
// CC-setting instructions so decode can stall branches until the CC is current.
module cc_gen_track #(
    parameter int         CNT_W    = 3,
    parameter logic [2:0] RESET_CC = 3'b010
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic [3:0]  issue_opcode,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic        wb_sets_cc,
    input  logic [15:0] wb_data,
    input  logic        flush,
    input  logic        br_req,
    output logic [2:0]  cc_out,
    output logic        cc_valid,
    output logic        br_stall,
    output logic        err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count;
    logic             setter_op;
    logic             wb_cc;
    logic             inc;
    logic             dec;
    logic [2:0]       wb_nzp;

    always_comb begin
        setter_op = 1'b0;
        case (issue_opcode)
            4'b0001, 4'b0101, 4'b1001,
            4'b0010, 4'b0110, 4'b1010,
            4'b1101: setter_op = 1'b1;
            default: setter_op = 1'b0;
        endcase
    end

    // A retire in the same cycle frees a slot, so a full counter can still accept an issue.
    assign wb_cc       = wb_valid & wb_sets_cc;
    assign dec         = wb_cc & (count != '0);
    assign issue_ready = (count != CNT_MAX) | dec;
    assign inc         = issue_valid & issue_ready & setter_op;
    assign cc_valid    = (count == '0);
    assign br_stall    = br_req & ~cc_valid;

    always_comb begin
        wb_nzp = 3'b000;
        if (wb_data == 16'h0000)
            wb_nzp = 3'b010;
        else if (wb_data[15])
            wb_nzp = 3'b100;
        else
            wb_nzp = 3'b001;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            cc_out        <= RESET_CC;
            err_underflow <= 1'b0;
        end else begin
            if (flush)
                count <= '0;
            else if (inc && !dec)
                count <= count + CNT_ONE;
            else if (dec && !inc)
                count <= count - CNT_ONE;

            // CC follows every CC-writing retire, even one that underflows or coincides with a flush.
            if (wb_cc) begin
                cc_out <= wb_nzp;
                if (count == '0)
                    err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cc_gen_track.sv
// Self-checking bench for cc_gen_track: directed scenarios followed by randomized
// traffic, compared against an arithmetic reference model of the CC/in-flight rules.
module tb_cc_gen_track;

    localparam int CNT_W = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic        issue_ready;
    logic        wb_valid;
    logic        wb_sets_cc;
    logic [15:0] wb_data;
    logic        flush;
    logic        br_req;
    logic [2:0]  cc_out;
    logic        cc_valid;
    logic        br_stall;
    logic        err_underflow;

    int          vectors    = 0;
    int          miscompares = 0;

    int          m_count;
    logic [2:0]  m_cc;
    logic        m_err;

    logic [3:0]  setter_list [7] = '{4'b0001, 4'b0101, 4'b1001, 4'b0010, 4'b0110, 4'b1010, 4'b1101};

    cc_gen_track #(.CNT_W(CNT_W), .RESET_CC(3'b010)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .issue_valid   (issue_valid),
        .issue_opcode  (issue_opcode),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_sets_cc    (wb_sets_cc),
        .wb_data       (wb_data),
        .flush         (flush),
        .br_req        (br_req),
        .cc_out        (cc_out),
        .cc_valid      (cc_valid),
        .br_stall      (br_stall),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic bit is_cc_setter(input logic [3:0] op);
        foreach (setter_list[i])
            if (setter_list[i] == op)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] nzp_of(input logic [15:0] d);
        if ($signed(d) < 0)
            return 3'b100;
        else if (d == 16'd0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_cc    = 3'b010;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        bit retire, freed, ready, accepted;
        retire   = wb_valid && wb_sets_cc;
        freed    = retire && (m_count > 0);
        ready    = (m_count < MAXC) || freed;
        accepted = issue_valid && ready && is_cc_setter(issue_opcode);
        if (retire) begin
            if (m_count == 0)
                m_err = 1'b1;
            m_cc = nzp_of(wb_data);
        end
        if (flush)
            m_count = 0;
        else
            m_count = m_count + int'(accepted) - int'(freed);
    endtask

    task automatic checkOutput(input string tag);
        logic exp_valid, exp_ready, exp_stall;
        bit   freed;
        freed     = wb_valid && wb_sets_cc && (m_count > 0);
        exp_valid = (m_count == 0);
        exp_ready = (m_count < MAXC) || freed;
        exp_stall = br_req && (m_count != 0);
        vectors += 5;
        assert (cc_out === m_cc) else begin
            miscompares++;
            $error("[TB] FAIL %s cc_out got %b expected %b", tag, cc_out, m_cc);
        end
        assert (cc_valid === exp_valid) else begin
            miscompares++;
            $error("[TB] FAIL %s cc_valid got %b expected %b", tag, cc_valid, exp_valid);
        end
        assert (issue_ready === exp_ready) else begin
            miscompares++;
            $error("[TB] FAIL %s issue_ready got %b expected %b", tag, issue_ready, exp_ready);
        end
        assert (br_stall === exp_stall) else begin
            miscompares++;
            $error("[TB] FAIL %s br_stall got %b expected %b", tag, br_stall, exp_stall);
        end
        assert (err_underflow === m_err) else begin
            miscompares++;
            $error("[TB] FAIL %s err_underflow got %b expected %b", tag, err_underflow, m_err);
        end
    endtask

    // One cycle: drive after the falling edge, check mid-cycle, advance the model at the rising edge.
    task automatic applyStimulus(input string tag, input logic iv, input logic [3:0] op,
                                 input logic wv, input logic wsc, input logic [15:0] d,
                                 input logic fl, input logic br);
        @(negedge clk);
        issue_valid  = iv;
        issue_opcode = op;
        wb_valid     = wv;
        wb_sets_cc   = wsc;
        wb_data      = d;
        flush        = fl;
        br_req       = br;
        #1;
        checkOutput(tag);
        @(posedge clk);
        model_step();
    endtask

    initial begin
        logic [15:0] rd;
        reset_n      = 1'b0;
        issue_valid  = 1'b0;
        issue_opcode = 4'h0;
        wb_valid     = 1'b0;
        wb_sets_cc   = 1'b0;
        wb_data      = 16'h0;
        flush        = 1'b0;
        br_req       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus("reset_idle", 0, 4'h0, 0, 0, 16'h0, 0, 0);

        applyStimulus("add_issue", 1, 4'b0001, 0, 0, 16'h0, 0, 1);
        applyStimulus("add_pending_stall", 0, 4'h0, 1, 1, 16'h8000, 0, 1);
        applyStimulus("add_resolved", 0, 4'h0, 0, 0, 16'h0, 0, 1);

        for (int i = 0; i < 7; i++)
            applyStimulus("fill", 1, 4'b0001, 0, 0, 16'h0, 0, 0);
        applyStimulus("full_blocked", 1, 4'b0101, 0, 0, 16'h0, 0, 1);
        applyStimulus("full_swap", 1, 4'b0110, 1, 1, 16'h0000, 0, 1);
        applyStimulus("full_after_swap", 0, 4'h0, 0, 0, 16'h0, 0, 0);
        for (int i = 0; i < 7; i++)
            applyStimulus("drain", 0, 4'h0, 1, 1, 16'h1234, 0, 1);

        applyStimulus("lea", 1, 4'b1110, 0, 0, 16'h0, 0, 1);
        applyStimulus("br", 1, 4'b0000, 0, 0, 16'h0, 0, 1);
        applyStimulus("jsr", 1, 4'b0100, 0, 0, 16'h0, 0, 1);
        applyStimulus("non_setters_idle", 0, 4'h0, 0, 0, 16'h0, 0, 1);

        for (int i = 0; i < 3; i++)
            applyStimulus("pre_flush", 1, 4'b1001, 0, 0, 16'h0, 0, 0);
        applyStimulus("flush_wb", 1, 4'b0001, 1, 1, 16'h0005, 1, 1);
        applyStimulus("post_flush", 0, 4'h0, 0, 0, 16'h0, 0, 1);

        applyStimulus("underflow_wb", 0, 4'h0, 1, 1, 16'hFFFF, 0, 0);
        applyStimulus("underflow_sticky", 1, 4'b1101, 0, 0, 16'h0, 0, 0);
        applyStimulus("underflow_sticky2", 0, 4'h0, 0, 0, 16'h0, 0, 1);

        @(negedge clk);
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        wb_sets_cc  = 1'b0;
        flush       = 1'b0;
        br_req      = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            bit issue_heavy;
            issue_heavy = ((i / 50) % 2) == 0;
            case ($urandom_range(0, 5))
                0:       rd = 16'h0000;
                1:       rd = 16'h8000;
                2:       rd = 16'h7FFF;
                3:       rd = 16'hFFFF;
                default: rd = 16'($urandom);
            endcase
            applyStimulus("random",
                          issue_heavy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3),
                          4'($urandom),
                          issue_heavy ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 9) < 8),
                          rd,
                          ($urandom_range(0, 31) == 0),
                          1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cc_gen_track.md
Name: cc_gen_track

Overview:
- Producer end of the branch-condition interface. Generates and holds the LC-3b n/z/p condition codes consumed by branch/JSR evaluation in decode.
- Also tracks in-flight CC-setting instructions between issue and writeback. Stalls branch evaluation until the CC value is architecturally current.
- Sits between the decode/issue stage (increments) and the writeback stage (updates CC, decrements).

Parameters:
- CNT_W, 3, width of in-flight counter; max outstanding CC-setters = 2^CNT_W - 1.
- RESET_CC, 3'b010, n/z/p value loaded on reset (Z set).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction issuing from decode this cycle.
- issue_opcode  in  4  opcode of issuing instruction.
- issue_ready  out  1  counter can accept a CC-setter; decode holds when low.
- wb_valid  in  1  instruction retiring in writeback this cycle.
- wb_sets_cc  in  1  retiring instruction writes CC.
- wb_data  in  16  value written to destination register.
- flush  in  1  pipeline squash; all younger issued instructions discarded.
- br_req  in  1  decode holds a BR/JSR needing CC.
- cc_out  out  3  registered n/z/p, bit2=n, bit1=z, bit0=p.
- cc_valid  out  1  no CC-setter in flight (count==0).
- br_stall  out  1  br_req & ~cc_valid.
- err_underflow  out  1  sticky: CC writeback seen with count==0.

Behaviour:
- Reset (async, reset_n low): count=0, cc_out=RESET_CC, err_underflow=0. Hence cc_valid=1, issue_ready=1, br_stall=0 while br_req=0.
- CC-setting opcodes: 0001 ADD, 0101 AND, 1001 NOT/XOR, 0010 LDB, 0110 LDW, 1010 LDI, 1101 SHF. All others (incl. 1110 LEA, 0000 BR, 0100 JSR) do not count.
- inc = issue_valid & issue_ready & cc_setter(issue_opcode).
- dec = wb_valid & wb_sets_cc & (count!=0).
- issue_ready = (count != 2^CNT_W-1) | dec. A same-cycle retire frees a slot.
- Counter next state:
  - inc&~dec: +1.
  - dec&~inc: -1.
  - both or neither: hold.
- CC update, registered, takes effect next edge on any wb_valid & wb_sets_cc, regardless of count:
  - n = wb_data[15].
  - z = (wb_data==0).
  - p = ~wb_data[15] & (wb_data!=0).
  - Exactly one bit is set.
- Underflow: wb_valid & wb_sets_cc with count==0 sets err_underflow (sticky until reset). Count stays 0; cc_out is still updated.
- Flush:
  - Next count = 0. Overrides inc and dec in the same cycle.
  - A writeback in the same cycle still updates cc_out.
  - The issue in the flush cycle is treated as squashed.
- Outputs:
  - cc_valid, issue_ready and br_stall are combinational from registered count plus current inputs (issue_ready only via dec).
  - cc_out is purely registered.
  - br_stall does not depend on flush.
- Latency: the CC from a writeback at edge k is visible on cc_out after edge k. cc_valid rises on the same edge the last pending setter retires, so the branch resolves in the cycle after writeback with no bypass.
- Count never wraps: saturation is prevented by issue_ready; decrement below 0 is blocked.
- Reset mid-operation discards all pending state immediately (asynchronous).

Test Plan:
- Reset then idle → cc_out=010, cc_valid=1, br_stall=0, issue_ready=1, err_underflow=0.
- Issue ADD (0001), br_req=1 held; next cycle wb_sets_cc with wb_data=16'h8000 → br_stall=1 until the wb edge; then cc_out=100, cc_valid=1, br_stall=0.
- Issue 7 consecutive ADDs with CNT_W=3, no wb → issue_ready=0 after the 7th. In the same cycle, issue LDW and retire with wb_data=0 → issue_ready=1, count stays 7, cc_out=010.
- Issue LEA (1110) and BR (0000) only → count stays 0, cc_valid remains 1.
- 3 ADDs pending, then flush with a simultaneous wb (wb_data=16'h0005) → next cycle count=0, cc_out=001, cc_valid=1.
- wb_sets_cc with count=0, wb_data=16'hFFFF → err_underflow=1 (stays 1), cc_out=100. Assert reset_n low mid-cycle → outputs return to reset values immediately.
